// File: rtl/conv2d_engine_if.sv
// Bus bundle between the register banks and the convolution engine.
`timescale 1ns/1ps
interface conv2d_engine_if #(
    parameter int unsigned img_bits    = 112,
    parameter int unsigned weight_bits = 28,
    parameter int unsigned bitwidth    = 7,
    parameter int unsigned result_bits = 63
);
    logic                   conv_en;
    logic [img_bits-1:0]    img;
    logic [weight_bits-1:0] weight;
    logic [bitwidth-1:0]    bias;
    logic [result_bits-1:0] result;
    logic                   conv_fin;

    modport master (
        output conv_en,
        output img,
        output weight,
        output bias,
        input  result,
        input  conv_fin
    );

    modport slave (
        input  conv_en,
        input  img,
        input  weight,
        input  bias,
        output result,
        output conv_fin
    );
endinterface

// File: rtl/conv2d_engine.sv
// Single-channel 2-D convolution: one output pixel per cycle, whole map
// presented at once with a one-cycle done pulse.
`timescale 1ns/1ps
module conv2d_engine #(
    parameter int unsigned weight_width   = 2,
    parameter int unsigned weight_height  = 2,
    parameter int unsigned img_width      = 4,
    parameter int unsigned img_height     = 4,
    parameter int unsigned padding_enable = 0,
    parameter int unsigned padding        = 0,
    parameter int unsigned stride         = 1,
    parameter int unsigned bitwidth       = 7,
    parameter int unsigned result_width   =
        (img_width - weight_width + 2 * ((padding_enable != 0) ? padding : 0)) / stride + 1,
    parameter int unsigned result_height  =
        (img_height - weight_height + 2 * ((padding_enable != 0) ? padding : 0)) / stride + 1,
    parameter int unsigned expand         = 4
) (
    input  logic           clk_en,
    input  logic           rst_n,
    conv2d_engine_if.slave bus
);

    localparam int unsigned PAD      = (padding_enable != 0) ? padding : 0;
    localparam int unsigned N        = result_width * result_height;
    localparam int unsigned IMG_BITS = img_width * img_height * bitwidth;
    localparam int unsigned W_BITS   = weight_width * weight_height * bitwidth;
    localparam int unsigned RES_BITS = N * bitwidth;
    localparam int unsigned ACC_W    = 2 * bitwidth + expand;
    localparam int unsigned IDX_W    = $clog2(N + 1);
    localparam int unsigned ROW_W    = $clog2(result_height + 1);
    localparam int unsigned COL_W    = $clog2(result_width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic                conv_en_q,  conv_en_d;
    logic [IMG_BITS-1:0] img_q,      img_d;
    logic [W_BITS-1:0]   weight_q,   weight_d;
    logic [bitwidth-1:0] bias_q,     bias_d;
    logic [IDX_W-1:0]    index_q,    index_d;
    logic [ROW_W-1:0]    row_q,      row_d;
    logic [COL_W-1:0]    col_q,      col_d;
    logic [RES_BITS-1:0] fmap_q,     fmap_d;
    logic [RES_BITS-1:0] result_q,   result_d;
    logic                conv_fin_q, conv_fin_d;

    logic [ACC_W-1:0]    acc_c;
    logic [bitwidth-1:0] pix_c;
    int                  pr;
    int                  pc;

    // Window sum for the current (row, col); taps falling in the zero border contribute nothing.
    always_comb begin
        acc_c = ACC_W'(bias_q);
        pr    = 0;
        pc    = 0;
        for (int i = 0; i < int'(weight_height); i++) begin
            for (int j = 0; j < int'(weight_width); j++) begin
                pr = int'(row_q) * int'(stride) + i - int'(PAD);
                pc = int'(col_q) * int'(stride) + j - int'(PAD);
                if (pr >= 0 && pr < int'(img_height) && pc >= 0 && pc < int'(img_width)) begin
                    acc_c = acc_c
                          + ACC_W'(img_q[(pr * int'(img_width) + pc) * int'(bitwidth) +: bitwidth])
                          * ACC_W'(weight_q[(i * int'(weight_width) + j) * int'(bitwidth) +: bitwidth]);
                end
            end
        end
    end

    // Result element keeps only the low bits (modular wrap).
    assign pix_c = bitwidth'(acc_c);

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        conv_en_d  = bus.conv_en;
        img_d      = img_q;
        weight_d   = weight_q;
        bias_d     = bias_q;
        index_d    = index_q;
        row_d      = row_q;
        col_d      = col_q;
        fmap_d     = fmap_q;
        result_d   = result_q;
        conv_fin_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.conv_en && !conv_en_q) begin
                    img_d    = bus.img;
                    weight_d = bus.weight;
                    bias_d   = bus.bias;
                    index_d  = '0;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                fmap_d[int'(index_q) * int'(bitwidth) +: bitwidth] = pix_c;
                index_d = index_q + IDX_W'(1);
                if (col_q == COL_W'(result_width - 1)) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
                // Last pixel: publish the map including the pixel written this cycle.
                if (index_q == IDX_W'(N - 1)) begin
                    result_d   = fmap_d;
                    conv_fin_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            conv_en_q  <= 1'b0;
            img_q      <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            index_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            fmap_q     <= '0;
            result_q   <= '0;
            conv_fin_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_en_q  <= conv_en_d;
            img_q      <= img_d;
            weight_q   <= weight_d;
            bias_q     <= bias_d;
            index_q    <= index_d;
            row_q      <= row_d;
            col_q      <= col_d;
            fmap_q     <= fmap_d;
            result_q   <= result_d;
            conv_fin_q <= conv_fin_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.conv_fin = conv_fin_q;

endmodule

// File: tb/tb_conv2d_engine.sv
// Bench for conv2d_engine: default, stride-2 and padded instances on shared stimulus.
`timescale 1ns/1ps
module tb_conv2d_engine;

    localparam int unsigned BW       = 7;
    localparam int unsigned IMG_BITS = 112;
    localparam int unsigned W_BITS   = 28;
    localparam int unsigned R0_BITS  = 63;
    localparam int unsigned R1_BITS  = 28;
    localparam int unsigned R2_BITS  = 175;
    localparam int unsigned CMP_W    = 256;

    logic                clk_en = 1'b0;
    logic                rst_n  = 1'b0;
    logic                conv_en;
    logic [IMG_BITS-1:0] img;
    logic [W_BITS-1:0]   weight;
    logic [BW-1:0]       bias;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt0 = 0;
    int lat;

    logic [CMP_W-1:0] q0[$];
    logic [CMP_W-1:0] q1[$];
    logic [CMP_W-1:0] q2[$];

    logic [CMP_W-1:0] nom_vec;
    logic [CMP_W-1:0] wrap_vec;
    logic [CMP_W-1:0] s2_vec;

    int nom_img[16] = '{3, 2, 4, 1, 2, 0, 6, 2, 6, 7, 1, 2, 5, 6, 4, 2};
    int nom_res[9]  = '{8, 13, 11, 14, 6, 13, 17, 16, 8};
    int s2_res[4]   = '{8, 11, 17, 8};

    always #100 clk_en = ~clk_en;

    conv2d_engine_if #(.img_bits(IMG_BITS), .weight_bits(W_BITS), .bitwidth(BW), .result_bits(R0_BITS)) bus0 ();
    conv2d_engine_if #(.img_bits(IMG_BITS), .weight_bits(W_BITS), .bitwidth(BW), .result_bits(R1_BITS)) bus1 ();
    conv2d_engine_if #(.img_bits(IMG_BITS), .weight_bits(W_BITS), .bitwidth(BW), .result_bits(R2_BITS)) bus2 ();

    assign bus0.conv_en = conv_en;
    assign bus0.img     = img;
    assign bus0.weight  = weight;
    assign bus0.bias    = bias;
    assign bus1.conv_en = conv_en;
    assign bus1.img     = img;
    assign bus1.weight  = weight;
    assign bus1.bias    = bias;
    assign bus2.conv_en = conv_en;
    assign bus2.img     = img;
    assign bus2.weight  = weight;
    assign bus2.bias    = bias;

    conv2d_engine u_dut (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .bus    (bus0)
    );

    conv2d_engine #(.stride(2)) u_dut_s2 (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .bus    (bus1)
    );

    conv2d_engine #(.padding_enable(1), .padding(1)) u_dut_p1 (
        .clk_en (clk_en),
        .rst_n  (rst_n),
        .bus    (bus2)
    );

    task automatic check_eq(input string tag, input logic [CMP_W-1:0] got, input logic [CMP_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference convolution on a 4x4 image with a 2x2 kernel.
    function automatic logic [CMP_W-1:0] model(input int st, input int pad);
        logic [CMP_W-1:0] res;
        logic [17:0]      acc;
        int               rw;
        int               rh;
        int               pr;
        int               pc;
        res = '0;
        rw  = (4 - 2 + 2 * pad) / st + 1;
        rh  = rw;
        for (int r = 0; r < rh; r++) begin
            for (int c = 0; c < rw; c++) begin
                acc = 18'(bias);
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        pr = r * st + i - pad;
                        pc = c * st + j - pad;
                        if (pr >= 0 && pr < 4 && pc >= 0 && pc < 4) begin
                            acc = acc + 18'(img[(pr * 4 + pc) * BW +: BW]) * 18'(weight[(i * 2 + j) * BW +: BW]);
                        end
                    end
                end
                res[(r * rw + c) * BW +: BW] = BW'(acc);
            end
        end
        return res;
    endfunction

    task automatic drive_nominal();
        for (int k = 0; k < 16; k++) begin
            img[k * BW +: BW] = BW'(nom_img[k]);
        end
        weight = '0;
        weight[0 * BW +: BW] = BW'(1);
        weight[3 * BW +: BW] = BW'(1);
        bias = BW'(5);
    endtask

    task automatic start();
        @(negedge clk_en);
        conv_en = 1'b1;
        q0.push_back(model(1, 0));
        q1.push_back(model(2, 0));
        q2.push_back(model(1, 1));
    endtask

    task automatic wait_fin(output int latency);
        latency = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_en);
            if (bus0.conv_fin === 1'b1) begin
                latency = k - 1;
                break;
            end
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk_en) begin
        if (bus0.conv_fin === 1'b1) begin
            fin_cnt0++;
            check_eq("sb0_pending", CMP_W'(q0.size() > 0), CMP_W'(1));
            if (q0.size() > 0) check_eq("sb0_result", CMP_W'(bus0.result), q0.pop_front());
        end
        if (bus1.conv_fin === 1'b1) begin
            check_eq("sb1_pending", CMP_W'(q1.size() > 0), CMP_W'(1));
            if (q1.size() > 0) check_eq("sb1_result", CMP_W'(bus1.result), q1.pop_front());
        end
        if (bus2.conv_fin === 1'b1) begin
            check_eq("sb2_pending", CMP_W'(q2.size() > 0), CMP_W'(1));
            if (q2.size() > 0) check_eq("sb2_result", CMP_W'(bus2.result), q2.pop_front());
        end
    end

    initial begin
        conv_en = 1'b0;
        drive_nominal();
        nom_vec  = '0;
        wrap_vec = '0;
        s2_vec   = '0;
        for (int k = 0; k < 9; k++) begin
            nom_vec[k * BW +: BW]  = BW'(nom_res[k]);
            wrap_vec[k * BW +: BW] = BW'(4);
        end
        for (int k = 0; k < 4; k++) begin
            s2_vec[k * BW +: BW] = BW'(s2_res[k]);
        end

        // Reset state
        #50;
        check_eq("rst_result0", CMP_W'(bus0.result), '0);
        check_eq("rst_fin0", CMP_W'(bus0.conv_fin), '0);
        check_eq("rst_result1", CMP_W'(bus1.result), '0);
        check_eq("rst_result2", CMP_W'(bus2.result), '0);
        @(negedge clk_en);
        rst_n = 1'b1;
        @(negedge clk_en);

        // Nominal run with exact latency and pulse width
        start();
        repeat (9) @(negedge clk_en);
        check_eq("pre_fin", CMP_W'(bus0.conv_fin), '0);
        check_eq("pre_result", CMP_W'(bus0.result), '0);
        @(negedge clk_en);
        check_eq("fin_at_9", CMP_W'(bus0.conv_fin), CMP_W'(1));
        check_eq("nominal", CMP_W'(bus0.result), nom_vec);
        @(negedge clk_en);
        check_eq("fin_width", CMP_W'(bus0.conv_fin), '0);
        conv_en = 1'b0;
        repeat (30) @(negedge clk_en);
        check_eq("stride2", CMP_W'(bus1.result), s2_vec);
        check_eq("pad_00", CMP_W'(bus2.result[(0 * 5 + 0) * BW +: BW]), CMP_W'(8));
        check_eq("pad_44", CMP_W'(bus2.result[(4 * 5 + 4) * BW +: BW]), CMP_W'(7));
        check_eq("pad_11", CMP_W'(bus2.result[(1 * 5 + 1) * BW +: BW]), CMP_W'(8));
        check_eq("hold", CMP_W'(bus0.result), nom_vec);

        // Modular wrap
        img    = '1;
        weight = '1;
        bias   = '0;
        start();
        wait_fin(lat);
        check_eq("wrap_latency", CMP_W'(lat), CMP_W'(9));
        check_eq("wrap", CMP_W'(bus0.result), wrap_vec);
        conv_en = 1'b0;
        repeat (30) @(negedge clk_en);

        // Held conv_en, image changed mid-run
        drive_nominal();
        fin_cnt0 = 0;
        start();
        repeat (2) @(negedge clk_en);
        img = '0;
        repeat (28) @(negedge clk_en);
        check_eq("retrig_count", CMP_W'(fin_cnt0), CMP_W'(1));
        check_eq("retrig_result", CMP_W'(bus0.result), nom_vec);
        conv_en = 1'b0;
        repeat (30) @(negedge clk_en);

        // Reset mid-run
        drive_nominal();
        fin_cnt0 = 0;
        start();
        repeat (4) @(negedge clk_en);
        rst_n   = 1'b0;
        conv_en = 1'b0;
        #1;
        check_eq("midrst_result0", CMP_W'(bus0.result), '0);
        check_eq("midrst_fin0", CMP_W'(bus0.conv_fin), '0);
        check_eq("midrst_result1", CMP_W'(bus1.result), '0);
        check_eq("midrst_result2", CMP_W'(bus2.result), '0);
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clk_en);
        rst_n = 1'b1;
        repeat (40) @(negedge clk_en);
        check_eq("midrst_nopulse", CMP_W'(fin_cnt0), '0);

        start();
        wait_fin(lat);
        check_eq("postrst_latency", CMP_W'(lat), CMP_W'(9));
        check_eq("postrst_result", CMP_W'(bus0.result), nom_vec);
        conv_en = 1'b0;
        repeat (30) @(negedge clk_en);
        check_eq("sb_drain", CMP_W'(q0.size() + q1.size() + q2.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
- Single-channel 2-D convolution engine: one image and one kernel (both flattened buses), computes sum(img×weight)+bias for every output position, returns the whole flattened feature map with a one-cycle done pulse.
- Sits between the image/weight register banks and the next CNN layer.
- The vendor global-reset primitive GTP_GRS is instantiated at bench/top level and is not part of this block.

Parameters:
- weight_width, 2, kernel columns
- weight_height, 2, kernel rows
- img_width, 4, image columns
- img_height, 4, image rows
- padding_enable, 0, 1 = zero-pad the image by `padding` on all four sides
- padding, 0, pad width in pixels; ignored when padding_enable=0
- stride, 1, window step in both directions
- bitwidth, 7, width of every pixel, weight, bias and result element
- result_width, (img_width-weight_width+2*padding)/stride+1, output columns
- result_height, (img_height-weight_height+2*padding)/stride+1, output rows
- expand, 4, extra accumulator guard bits; accumulator width is 2*bitwidth+expand

Ports:
- clk_en  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- conv_en  in  1  start request, level input, rising edge triggers
- img  in  img_width*img_height*bitwidth  image, element r*img_width+c at bits [(r*img_width+c)*bitwidth +: bitwidth]
- weight  in  weight_width*weight_height*bitwidth  kernel, same row-major LSB-first packing
- bias  in  bitwidth  bias added to every output
- result  out  result_width*result_height*bitwidth  feature map, same packing
- conv_fin  out  1  done pulse

Behaviour:
- Interface: one clock (clk_en); reset rst_n is asynchronous, active-low.
- All values are unsigned.
- out(r,c) = bias + Σ_i Σ_j P(r*stride+i, c*stride+j)·W(i,j), where P is the padded image (0 outside the original image).
- Accumulate at full accumulator width; result element = low bitwidth bits (mod 2^bitwidth, wrap, no saturation).
- Reset: state IDLE, result=0, conv_fin=0, index=0, internal buffers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - A start is conv_en sampled 1 at an edge after it was sampled 0 at the previous edge (a registered copy of conv_en gives edge detect).
  - On the start edge E0: capture img, weight and bias into internal registers, set index=0, go to RUN.
- RUN:
  - At each edge, compute output pixel `index` combinationally from the captured data and write it to the internal buffer; index++.
  - Output order is row-major.
  - At edge EN, where N=result_width*result_height, the last pixel is written, result is loaded from the buffer together with that last pixel, conv_fin goes 1, and the state goes to DONE.
- DONE: at the next edge, conv_fin goes 0 and the state goes to IDLE.
- conv_fin is high for exactly one cycle. Latency from start edge to conv_fin high is N cycles.
- result changes only at EN and otherwise holds its last value, including after conv_en drops.
- Changes to img, weight, bias or conv_en after E0 do not affect the current run.
- A new conv_en rising edge while in RUN or DONE is ignored.
- conv_en held high through completion does not retrigger; a low-to-high transition is required.
- Reset asserted mid-run aborts the run immediately: outputs go to their reset values and the partial result is discarded.

Test Plan:
- Nominal (defaults, 7-bit packing):
  - Stimulus: img rows [3 2 4 1],[2 0 6 2],[6 7 1 2],[5 6 4 2]; weight [[1,0],[0,1]]; bias 5; rst_n released at 300 ns; conv_en high 400–1100 ns; 200 ns clock period.
  - Required: result rows [8 13 11],[14 6 13],[17 16 8]; conv_fin single pulse exactly 9 cycles after the start edge; result 0 before that.
- Wrap:
  - Stimulus: all img=127, all weight=127, bias=0.
  - Required: every element = (4·16129) mod 128 = 4.
- No retrigger and input change:
  - Stimulus: conv_en held high for 30 cycles; img changed to all-zero 2 cycles after start.
  - Required: exactly one conv_fin pulse; result equals the nominal values.
- Reset mid-run:
  - Stimulus: rst_n low at cycle 4 of a run.
  - Required: result=0 and conv_fin=0 immediately; no pulse.
  - Then: a new conv_en rise after reset produces the nominal result.
- Stride/padding:
  - stride=2 with the nominal data → [8 11],[17 8].
  - padding_enable=1, padding=1, stride=1 → 5×5 result; out(0,0)=8, out(4,4)=2·1+5=7, out(1,1)=8.
